ram_access_arbiter: RTL and testbench
=====================================

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 The block SHALL have parameter num_requesters, default 3: number of FSM cores sharing one single-port RAM (range 2..8).
REQ-002 The block SHALL have parameter data_width, default 8: RAM word width.
REQ-003 The block SHALL have parameter addr_width, default 8: RAM address width.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset; asynchronous assertion, active-low.
REQ-006 Port access_request, input, num_requesters: bit n is requester n's access request.
REQ-007 Port access_granted, output, num_requesters: registered, one-hot or zero; bit n grants RAM ownership to requester n.
REQ-008 Port req_addr, input, num_requesters*addr_width: requester n's address is at slice [n*addr_width +: addr_width].
REQ-009 Port req_data, input, num_requesters*data_width: requester n's write data is at slice [n*data_width +: data_width].
REQ-010 Port req_wren, input, num_requesters: bit n is requester n's write enable.
REQ-011 Port ram_addr, output, addr_width: address to RAM.
REQ-012 Port ram_data, output, data_width: write data to RAM.
REQ-013 Port ram_wren, output, 1: write enable to RAM.
REQ-014 Port ram_q, input, data_width: RAM read data.
REQ-015 Port req_q, output, data_width: ram_q broadcast to all requesters, combinational pass-through.
REQ-016 Port busy, output, 1: high while the arbiter is in GRANT or RELEASE.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT and RELEASE, plus registers owner (index) and last_owner (index).
REQ-018 In IDLE with access_request nonzero, the next edge SHALL move to GRANT, set owner to the winner and set access_granted to one-hot(winner).
REQ-019 Winner selection SHALL be round-robin: the first set request bit scanning from (last_owner+1) mod num_requesters upward, wrapping past num_requesters-1 to 0.
REQ-020 Grant latency SHALL be exactly one cycle: a request sampled high in IDLE gives a grant visible the next cycle.
REQ-021 In GRANT, the state SHALL hold while access_request[owner]=1; requests from other requesters are ignored, with no preemption.
REQ-022 In GRANT, when access_request[owner]=0 at an edge, the state SHALL go to RELEASE, access_granted SHALL go to 0 and last_owner SHALL take owner.
REQ-023 RELEASE SHALL last exactly one cycle with no grant, then go to IDLE. Minimum owner-to-owner gap: 2 cycles without grant.
REQ-024 In IDLE with access_request=0, the state SHALL remain IDLE.
REQ-025 When access_granted is nonzero, ram_addr, ram_data and ram_wren SHALL combinationally equal the owner's req_addr, req_data and req_wren slices.
REQ-026 When access_granted is zero (IDLE or RELEASE), ram_addr and ram_data SHALL be 0 and ram_wren SHALL be 0, regardless of inputs.
REQ-027 Non-owners' req_wren SHALL never reach ram_wren.
REQ-028 An owner that drops and immediately re-raises its request SHALL pass through RELEASE. It regains the grant only if it is the round-robin winner in IDLE.
REQ-029 Any state encoding outside IDLE, GRANT and RELEASE SHALL go to IDLE on the next edge with grant cleared.

Reset
REQ-030 While rst_n=0, the block SHALL force, asynchronously: state=IDLE, access_granted=0, owner=0, last_owner=num_requesters-1, busy=0, ram_wren=0, ram_addr=0, ram_data=0.
REQ-031 Reset asserted mid-GRANT SHALL drop the grant immediately without waiting for a clock edge.
REQ-032 After rst_n rises, requester 0 SHALL have highest priority at the first arbitration.

Verification
REQ-033 Bench scenario: after reset, access_request=3'b111 -> access_granted=3'b001 one cycle later; ram_wren follows req_wren[0] only.
REQ-034 Bench scenario: owner 0 drops its request -> grant 0 for 2 cycles -> access_granted=3'b010; then 3'b100; then 3'b001 (wrap-around).
REQ-035 Bench scenario: owner 1 writes addr 8'h2A, data 8'h5C while requester 2 drives wren=1, addr 8'hFF -> RAM sees only 8'h2A/8'h5C with wren=1.
REQ-036 Bench scenario: no grant, all req_wren=1 -> ram_wren=0, ram_addr=0, ram_data=0.
REQ-037 Bench scenario: rst_n pulled low mid-GRANT between clock edges -> access_granted=0 and busy=0 immediately; after release, request 3'b110 -> grant 3'b010.
REQ-038 Bench scenario: single requester 2 holds its request for 300 cycles -> the grant stays on 3'b100 throughout, and ram_q equals req_q on every cycle.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Bus between the shared single-port RAM, its requesters and the arbiter.
// Requesters hold access_request high for as long as they need the RAM. The arbiter answers with a
// registered one-hot access_granted. The owner keeps the RAM until it drops its request; there is no preemption.
interface ram_access_arbiter_if #(
  parameter int num_requesters = 3,
  parameter int data_width     = 8,
  parameter int addr_width     = 8
);
  logic [num_requesters-1:0]            access_request;
  logic [num_requesters-1:0]            access_granted;
  logic [num_requesters*addr_width-1:0] req_addr;
  logic [num_requesters*data_width-1:0] req_data;
  logic [num_requesters-1:0]            req_wren;
  logic [addr_width-1:0]                ram_addr;
  logic [data_width-1:0]                ram_data;
  logic                                 ram_wren;
  logic [data_width-1:0]                ram_q;
  logic [data_width-1:0]                req_q;
  logic                                 busy;
  logic [1:0]                           dbg_state;

  modport master (
    output access_request, req_addr, req_data, req_wren, ram_q,
    input  access_granted, ram_addr, ram_data, ram_wren, req_q, busy, dbg_state
  );

  modport slave (
    input  access_request, req_addr, req_data, req_wren, ram_q,
    output access_granted, ram_addr, ram_data, ram_wren, req_q, busy, dbg_state
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter giving several FSM cores exclusive ownership of one single-port RAM.
// The owner's address, data and write enable are muxed to the RAM. Every hand-over passes through one RELEASE cycle.
module ram_access_arbiter #(
  parameter int num_requesters = 3,
  parameter int data_width     = 8,
  parameter int addr_width     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram_access_arbiter_if.slave    bus
);
  localparam int IDX_W = $clog2(num_requesters);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_owner;
  logic [IDX_W-1:0]          r_last_owner;
  logic [num_requesters-1:0] r_granted;

  logic [IDX_W-1:0]          w_winner;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_found;
  logic                      w_active;

  // Scan starts just after the previous owner, so the last owner has the lowest priority.
  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= num_requesters; i++) begin
      w_idx = IDX_W'((int'(r_last_owner) + i) % num_requesters);
      if (!w_found && bus.access_request[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(num_requesters - 1);
      r_granted    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state   <= GRANT;
            r_owner   <= w_winner;
            r_granted <= num_requesters'(1) << w_winner;
          end
        end
        GRANT: begin
          if (!bus.access_request[r_owner]) begin
            r_state      <= RELEASE;
            r_granted    <= '0;
            r_last_owner <= r_owner;
          end
        end
        RELEASE: begin
          r_state   <= IDLE;
          r_granted <= '0;
        end
        default: begin
          r_state   <= IDLE;
          r_granted <= '0;
        end
      endcase
    end
  end

  assign w_active = |r_granted;

  assign bus.access_granted = r_granted;
  assign bus.ram_addr  = w_active ? bus.req_addr[r_owner*addr_width +: addr_width] : '0;
  assign bus.ram_data  = w_active ? bus.req_data[r_owner*data_width +: data_width] : '0;
  assign bus.ram_wren  = w_active & bus.req_wren[r_owner];
  assign bus.req_q     = bus.ram_q;
  assign bus.busy      = (r_state == GRANT) || (r_state == RELEASE);
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: directed scenarios followed by random traffic.
// A cycle-level ownership/cooldown model supplies every expected value.
module tb_ram_access_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_access_arbiter_if #(.num_requesters(N), .data_width(DW), .addr_width(AW)) bus ();

  ram_access_arbiter #(.num_requesters(N), .data_width(DW), .addr_width(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // reference model: current owner (-1 none), no-grant cooldown cycles left, previous owner
  int m_owner;
  int m_cool;
  int m_last;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cool  = 0;
    m_last  = N - 1;
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (m_owner >= 0) begin
      if (!bus.access_request[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (bus.access_request != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (bus.access_request[c]) begin
          m_owner = c;
          break;
        end
      end
    end
    exp_q.push_back((m_owner >= 0) ? N'(1) << m_owner : '0);
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_grant;
    e_grant = exp_q.pop_front();
    chk("grant", 32'(bus.access_granted), 32'(e_grant));
    chk("busy", 32'(bus.busy), 32'((m_owner >= 0) || (m_cool > 0)));
    if (m_owner >= 0) begin
      chk("ram_addr", 32'(bus.ram_addr), 32'(bus.req_addr[m_owner*AW +: AW]));
      chk("ram_data", 32'(bus.ram_data), 32'(bus.req_data[m_owner*DW +: DW]));
      chk("ram_wren", 32'(bus.ram_wren), 32'(bus.req_wren[m_owner]));
    end else begin
      chk("ram_addr_idle", 32'(bus.ram_addr), 32'h0);
      chk("ram_data_idle", 32'(bus.ram_data), 32'h0);
      chk("ram_wren_idle", 32'(bus.ram_wren), 32'h0);
    end
    chk("req_q", 32'(bus.req_q), 32'(bus.ram_q));
  endtask

  // driver: inputs change only after the falling edge; one rising edge per call
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic randomize_data();
    for (int n = 0; n < N; n++) begin
      bus.req_addr[n*AW +: AW] = AW'($urandom_range(0, 255));
      bus.req_data[n*DW +: DW] = DW'($urandom_range(0, 255));
    end
    bus.req_wren = N'($urandom_range(0, (1 << N) - 1));
    bus.ram_q    = DW'($urandom_range(0, 255));
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.access_request = '0;
    bus.req_addr       = '0;
    bus.req_data       = '0;
    bus.req_wren       = '0;
    bus.ram_q          = '0;
    model_reset();

    // reset state, with garbage on the requester side
    randomize_data();
    bus.req_wren = '1;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.access_granted), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_wren", 32'(bus.ram_wren), 32'h0);
    chk("rst_addr", 32'(bus.ram_addr), 32'h0);
    chk("rst_data", 32'(bus.ram_data), 32'h0);
    rst_n = 1'b1;

    // all request after reset: requester 0 wins, only its wren reaches the RAM
    bus.access_request = 3'b111;
    bus.req_wren       = 3'b110;
    step();
    chk("first_grant", 32'(bus.access_granted), 32'h1);
    chk("wren_owner0_low", 32'(bus.ram_wren), 32'h0);
    bus.req_wren = 3'b001;
    #1;
    chk("wren_owner0_high", 32'(bus.ram_wren), 32'h1);

    // round robin with two-cycle gaps and wrap-around
    bus.access_request = 3'b110;
    step(); chk("gap0a", 32'(bus.access_granted), 32'h0);
    step(); chk("gap0b", 32'(bus.access_granted), 32'h0);
    step(); chk("rr_1", 32'(bus.access_granted), 32'h2);
    bus.access_request = 3'b101;
    repeat (3) step();
    chk("rr_2", 32'(bus.access_granted), 32'h4);
    bus.access_request = 3'b011;
    repeat (3) step();
    chk("rr_wrap_0", 32'(bus.access_granted), 32'h1);

    // owner 1 writes while requester 2 also drives a write
    bus.access_request = 3'b110;
    bus.req_addr[1*AW +: AW] = 8'h2A;
    bus.req_data[1*DW +: DW] = 8'h5C;
    bus.req_addr[2*AW +: AW] = 8'hFF;
    bus.req_data[2*DW +: DW] = 8'h33;
    bus.req_wren = 3'b110;
    repeat (3) step();
    chk("own1_grant", 32'(bus.access_granted), 32'h2);
    chk("own1_addr", 32'(bus.ram_addr), 32'h2A);
    chk("own1_data", 32'(bus.ram_data), 32'h5C);
    chk("own1_wren", 32'(bus.ram_wren), 32'h1);

    // nobody granted, everyone tries to write
    bus.access_request = 3'b000;
    bus.req_wren       = 3'b111;
    repeat (3) step();
    chk("idle_wren", 32'(bus.ram_wren), 32'h0);
    chk("idle_addr", 32'(bus.ram_addr), 32'h0);
    chk("idle_data", 32'(bus.ram_data), 32'h0);

    // asynchronous reset in the middle of a grant
    bus.access_request = 3'b001;
    step();
    chk("pre_rst_grant", 32'(bus.access_granted), 32'h1);
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(bus.access_granted), 32'h0);
    chk("async_rst_busy", 32'(bus.busy), 32'h0);
    chk("async_rst_wren", 32'(bus.ram_wren), 32'h0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    bus.access_request = 3'b110;
    step();
    chk("post_rst_grant", 32'(bus.access_granted), 32'h2);

    // long hold by requester 2
    bus.access_request = 3'b100;
    repeat (3) step();
    for (int c = 0; c < 300; c++) begin
      randomize_data();
      step();
      chk("hold_grant", 32'(bus.access_granted), 32'h4);
    end

    // random traffic: requests mostly persist so ownership spans several cycles
    for (int c = 0; c < 600; c++) begin
      randomize_data();
      if ($urandom_range(0, 3) == 0)
        bus.access_request = N'($urandom_range(0, (1 << N) - 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
